obstacle_lanes: RTL
===================

OBSTACLE_LANES -- requirements
Module: obstacle_lanes

Interface
REQ-001 Parameter NUM_LANES, default 4: number of horizontal obstacle lanes.
REQ-002 Parameter NUM_CELLS, default 20: cells per lane; legal range 2..32.
REQ-003 Parameter CELL_W, default 32: cell width in pixels; power of two.
REQ-004 Parameter LANE_H, default 48: lane height in pixels.
REQ-005 Parameter LANE_Y0, default 144: top pixel row of lane 0.
REQ-006 Parameter TICK_DIV, default 12_500_000: clock cycles per movement tick; legal minimum 2.
REQ-007 clock  in  1  single system clock; every register is on its rising edge.
REQ-008 reset  in  1  synchronous, active-low reset.
REQ-009 enable  in  1  high = obstacles move; low = positions, tick counter and skip counters all freeze.
REQ-010 next_x  in  10  x coordinate of the next pixel, from vga_driver.
REQ-011 next_y  in  10  y coordinate of the next pixel, from vga_driver.
REQ-012 frog_lane  in  $clog2(NUM_LANES)  lane the frog occupies.
REQ-013 frog_cell  in  5  cell the frog occupies.
REQ-014 frog_valid  in  1  frog is inside the lane field.
REQ-015 color_out  out  8  RRRGGGBB pixel colour for (next_x, next_y).
REQ-016 collision  out  1  an obstacle occupies the frog's cell.
REQ-017 tick  out  1  one-cycle pulse marking each movement tick.

Function
REQ-018 The tick counter shall count 0..TICK_DIV-1 while enable=1 and wrap to 0; tick=1 for exactly the cycle in which the count equals TICK_DIV-1.
REQ-019 Lane i shall hold a skip counter 0..i; on tick, if skip==i the lane steps and skip returns to 0, otherwise skip increments by 1 (lane i moves once every i+1 ticks).
REQ-020 Even lanes shall move right (pos+1, NUM_CELLS-1 wraps to 0); odd lanes shall move left (pos-1, 0 wraps to NUM_CELLS-1).
REQ-021 The pixel in lane i shall satisfy LANE_Y0+i*LANE_H <= next_y < LANE_Y0+(i+1)*LANE_H (lower bound inclusive, upper bound exclusive).
REQ-022 The pixel cell index shall be next_x >> log2(CELL_W); x >= NUM_CELLS*CELL_W lies in no cell.
REQ-023 color_out shall be OBST_COLOR (8'b00011100) when the pixel's lane and cell match that lane's position, and BG_COLOR (8'h00) otherwise; it is registered, so the value for (next_x, next_y) appears one cycle later.
REQ-024 collision shall be registered: 1 when frog_valid=1 and pos[frog_lane]==frog_cell, sampled each cycle; frog_lane >= NUM_LANES shall give 0.
REQ-025 When a step and a collision check fall in the same cycle, the check shall use the pre-step position; the new position is visible on the next cycle.
REQ-026 Deasserting enable mid-count shall hold the count; reasserting it shall resume from the held value without issuing an extra tick.

Reset
REQ-027 When reset=0 at a clock edge: tick counter=0, all skip counters=0, even-lane pos=0, odd-lane pos=NUM_CELLS-1, color_out=8'h00, collision=0, tick=0.
REQ-028 Reset shall take priority over enable and tick; a reset asserted mid-count discards the partial count.

Structure
REQ-029 Package frogger_pkg shall hold OBST_COLOR, BG_COLOR, the 10-bit coordinate width and the cell-index width.
REQ-030 Per-lane position and skip logic shall live in a sub-module lane_stepper (parameters LANE_IDX, NUM_CELLS, DIR), instantiated NUM_LANES times by a generate loop.
REQ-031 The y-to-lane decode shall use parallel range compares; no dividers.

Verification (bench parameters: NUM_LANES=2, NUM_CELLS=4, TICK_DIV=4, CELL_W=32, LANE_H=48, LANE_Y0=144)
REQ-032 Reset then enable=1 for 16 cycles -> tick pulses at cycles 4, 8, 12, 16; lane 0 pos 0->1->2->3->0 (wraps); lane 1 pos 3->2->1.
REQ-033 next_y=144, next_x=0 just after reset -> color_out=8'h1C one cycle later; next_y=192 (lane 1, pos 3), next_x=96 -> 8'h1C; next_y=143 -> 8'h00; next_x=128 -> 8'h00.
REQ-034 frog_lane=1, frog_cell=2, frog_valid=1 -> collision rises on the cycle after lane 1 reaches pos 2 and falls after lane 1 leaves pos 2; frog_valid=0 -> collision=0.
REQ-035 enable=0 for 10 cycles at count 2, then enable=1 -> next tick after 2 more cycles; positions unchanged during the pause.
REQ-036 reset=0 for one cycle while lane 0 is at pos 2 and the count is 3 -> next cycle pos=0, count=0, tick=0, color_out=8'h00.

Source files
------------

// File: rtl/frogger_pkg.sv
// Shared constants for the frogger video datapath: colours and coordinate/cell widths.
package frogger_pkg;

  localparam int COORD_W    = 10;
  localparam int CELL_IDX_W = 5;

  localparam logic [7:0] OBST_COLOR = 8'b00011100;
  localparam logic [7:0] BG_COLOR   = 8'h00;

endpackage

// File: rtl/obstacle_lanes_lane_stepper.sv
// One obstacle lane: a skip counter that divides the movement tick by LANE_IDX+1
// and a wrapping cell position that moves right (DIR=0) or left (DIR=1).
module lane_stepper
  import frogger_pkg::*;
#(
  parameter int LANE_IDX  = 0,
  parameter int NUM_CELLS = 20,
  parameter int DIR       = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  step,
  output logic [CELL_IDX_W-1:0] pos
);

  localparam int SKIP_W = (LANE_IDX > 0) ? $clog2(LANE_IDX + 1) : 1;
  localparam logic [SKIP_W-1:0]     SKIP_MAX = SKIP_W'(LANE_IDX);
  localparam logic [CELL_IDX_W-1:0] POS_MAX  = CELL_IDX_W'(NUM_CELLS - 1);
  localparam logic [CELL_IDX_W-1:0] POS_RST  = (DIR == 0) ? '0 : POS_MAX;

  logic [SKIP_W-1:0]     skip_p0;
  logic [CELL_IDX_W-1:0] pos_p0;
  logic [CELL_IDX_W-1:0] pos_next;

  always_comb begin
    pos_next = pos_p0;
    if (DIR == 0) begin
      pos_next = (pos_p0 == POS_MAX) ? '0 : pos_p0 + 1'b1;
    end else begin
      pos_next = (pos_p0 == '0) ? POS_MAX : pos_p0 - 1'b1;
    end
  end

  // stage p0: skip counter and lane position
  always_ff @(posedge clock) begin
    if (!reset) begin
      skip_p0 <= '0;
      pos_p0  <= POS_RST;
    end else if (step) begin
      if (skip_p0 == SKIP_MAX) begin
        skip_p0 <= '0;
        pos_p0  <= pos_next;
      end else begin
        skip_p0 <= skip_p0 + 1'b1;
      end
    end
  end

  assign pos = pos_p0;

endmodule

// File: rtl/obstacle_lanes.sv
// Scrolling obstacle lanes: movement tick generation, per-lane steppers,
// registered pixel colour lookup and registered frog collision detect.
module obstacle_lanes
  import frogger_pkg::*;
#(
  parameter int NUM_LANES  = 4,
  parameter int NUM_CELLS  = 20,
  parameter int CELL_W     = 32,
  parameter int LANE_H     = 48,
  parameter int LANE_Y0    = 144,
  parameter int TICK_DIV   = 12_500_000,
  localparam int LANE_SEL_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [COORD_W-1:0]    next_x,
  input  logic [COORD_W-1:0]    next_y,
  input  logic [LANE_SEL_W-1:0] frog_lane,
  input  logic [4:0]            frog_cell,
  input  logic                  frog_valid,
  output logic [7:0]            color_out,
  output logic                  collision,
  output logic                  tick
);

  localparam int CNT_W      = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int CELL_SHIFT = $clog2(CELL_W);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0]      tick_cnt_p0;
  logic [CELL_IDX_W-1:0] lane_pos [NUM_LANES];

  // stage p0: free-running movement tick divider, frozen while disabled
  always_ff @(posedge clock) begin
    if (!reset) begin
      tick_cnt_p0 <= '0;
    end else if (enable) begin
      tick_cnt_p0 <= (tick_cnt_p0 == CNT_MAX) ? '0 : tick_cnt_p0 + 1'b1;
    end
  end

  assign tick = enable && (tick_cnt_p0 == CNT_MAX);

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    lane_stepper #(
      .LANE_IDX  (gi),
      .NUM_CELLS (NUM_CELLS),
      .DIR       (gi % 2)
    ) u_stepper (
      .clock (clock),
      .reset (reset),
      .step  (tick),
      .pos   (lane_pos[gi])
    );
  end

  logic [NUM_LANES-1:0] y_in_lane;
  logic                 x_in_field;
  logic [COORD_W-1:0]   x_cell;
  logic                 pix_hit;
  logic                 frog_hit;

  // Lane decode is a bank of range compares; positions read here are pre-step.
  always_comb begin
    y_in_lane  = '0;
    x_cell     = next_x >> CELL_SHIFT;
    x_in_field = int'(next_x) < NUM_CELLS * CELL_W;
    pix_hit    = 1'b0;
    frog_hit   = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      y_in_lane[i] = (int'(next_y) >= LANE_Y0 + i * LANE_H) &&
                     (int'(next_y) <  LANE_Y0 + (i + 1) * LANE_H);
      if (y_in_lane[i] && x_in_field && (x_cell == COORD_W'(lane_pos[i]))) begin
        pix_hit = 1'b1;
      end
      if (frog_valid && (int'(frog_lane) == i) && (frog_cell == lane_pos[i])) begin
        frog_hit = 1'b1;
      end
    end
  end

  logic [7:0] color_p1;
  logic       collision_p1;

  // stage p1: registered pixel colour and collision flag
  always_ff @(posedge clock) begin
    if (!reset) begin
      color_p1     <= BG_COLOR;
      collision_p1 <= 1'b0;
    end else begin
      color_p1     <= pix_hit ? OBST_COLOR : BG_COLOR;
      collision_p1 <= frog_hit;
    end
  end

  assign color_out = color_p1;
  assign collision = collision_p1;

endmodule
